snow64_bfloat16_div_fsm: RTL
============================

# snow64_bfloat16_div_fsm

Sequential BFloat16 divider front/back end for the Snow64 vector FPU. It resolves special operands locally and feeds the significands of normal operands to an internal `LongDivU16ByU8` instance. It then normalizes the 9-bit quotient and packs the exponent into a truncated BFloat16 result. It sits between the FPU operand-dispatch stage and the result writeback mux, and presents the same start/valid/can-accept handshake as the integer divider.

## Interface

Parameters:
- None; widths are fixed by BFloat16 (1 sign, 8 exponent, 7 mantissa bits).

Ports:
- `clk`  in  1  sole clock.
- `in_rst_n`  in  1  reset; synchronous, active-low.
- `in_start`  in  1  command strobe; sampled only while `out_can_accept_cmd` is high.
- `in_a`  in  16  dividend, BFloat16.
- `in_b`  in  16  divisor, BFloat16.
- `out_data_valid`  out  1  result valid; held high until the next accepted `in_start`.
- `out_can_accept_cmd`  out  1  equals `(state == ST_IDLE) && div_can_accept`.
- `out_data`  out  16  quotient, BFloat16; held stable while valid.

## Operation

States: `ST_IDLE`, `ST_SPECIAL`, `ST_DIV_START`, `ST_DIV_WAIT`, `ST_NORMALIZE`.

**ST_IDLE**
- On accepted `in_start`: capture operands and clear `out_data_valid`.
- Classify operands:
  - exp == 0 → zero; subnormals are flushed.
  - exp == 255, mant == 0 → inf.
  - exp == 255, mant != 0 → NaN.
- Any special operand → `ST_SPECIAL`; otherwise → `ST_DIV_START`.

**ST_SPECIAL** (resolved by priority)
- Any NaN, 0/0 or inf/inf → `16'h7FC0`.
- x/0 or inf/x → signed inf.
- 0/x or x/inf → signed zero.
- Set valid, return to `ST_IDLE`.

**ST_DIV_START**
- Pulse divider `in_start` for exactly one cycle.
- Divider `in_a = {1'b1, ma, 8'h00}`; divider `in_b = {1'b1, mb}`.

**ST_DIV_WAIT**
- Entered one cycle after the pulse.
- Exit when divider `out_data_valid` is high; latch `q = out_data[8:0]`.
- The cycle directly after the pulse is skipped, because the divider's stale valid has not yet dropped.

**ST_NORMALIZE**
- q is always in [128, 511].
- `q[8]`: mant = `q[7:1]`, e = ea − eb + 127.
- Otherwise: mant = `q[6:0]`, e = ea − eb + 126.
- e is computed 10-bit signed; mantissa is truncated, no rounding.
- e ≥ 255 → signed inf (overflow).
- e ≤ 0 → signed zero (underflow).
- Sign = sa ^ sb for all non-NaN results.
- Set valid, return to `ST_IDLE`.

**Reset**
- `in_rst_n` low at a clock edge → `ST_IDLE`, `out_data_valid` = 0, `out_data` = 0, divider start = 0.
- The divider has no reset; a command in flight completes and is discarded.
- `out_can_accept_cmd` stays low until the divider reports ready.

## Timing

- Accepting edge is T0.
- Special path: `out_data_valid` high after T2.
- Normal path:
  - divider start registered at T0, seen by the divider at T1;
  - divider valid visible after T6, latched at T7;
  - `out_data_valid` high after T8 (8-cycle latency).
- `out_can_accept_cmd` is low from T0 through the cycle that sets valid.
- Back-to-back commands: next `in_start` may be accepted on the edge after valid rises.
- `in_start` while busy is ignored.
- `in_start` coincident with reset is ignored.

## Configuration

- `SNOW64_BFLOAT16_DIV_FLAGS_EN` defined:
  - adds port `out_flags [2:0]` = {div_by_zero, overflow, underflow};
  - flags are registered with `out_data`, cleared on accept and reset;
  - 0/0 sets div_by_zero.
- Undefined: port absent, flag logic removed, data path identical.

## Test plan

- `16'h3F80` / `16'h3F80` → `16'h3F80`, valid 8 cycles after accept.
- `16'h4040` / `16'h4000` → `16'h3FC0` (q = 384, `q[8]` path).
- `16'h3F80` / `16'h4040` → `16'h3EAA` (q = 170, truncated).
- `16'hC000` / `16'h0000` → `16'hFF80` in 2 cycles; `out_flags = 3'b100` when `_FLAGS_EN`.
- `16'h7F00` / `16'h0080` → `16'h7F80` overflow; `16'h0080` / `16'h7F00` → `16'h0000` underflow.
- Reset held one cycle mid `ST_DIV_WAIT`:
  - valid = 0, `out_can_accept_cmd` low until the divider is ready;
  - next command `16'h4000` / `16'h3F80` → `16'h4000`.

Source files
------------

// File: rtl/snow64_bfloat16_div_fsm.sv
// BFloat16 divider: special-operand resolution, iterative 16/8 significand divide, normalize/pack.
// Optional feature: define SNOW64_BFLOAT16_DIV_FLAGS_EN to add out_flags = {div_by_zero, overflow, underflow}.

module snow64_long_div_u16_by_u8 (
  input  logic        clk,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [7:0]  in_b,
  output logic        out_data_valid,
  output logic        out_can_accept_cmd,
  output logic [15:0] out_data
);
  localparam int unsigned STEPS = 4;
  localparam int unsigned BITS_PER_STEP = 4;

  logic        busy;
  logic [2:0]  cnt;
  logic [7:0]  den;
  logic [7:0]  rem;
  logic [15:0] quo;
  logic [7:0]  rem_nx;
  logic [15:0] quo_nx;
  logic [8:0]  trial;

  // Restoring division, dividend shifted out of quo while quotient bits shift in.
  always_comb begin
    rem_nx = rem;
    quo_nx = quo;
    trial  = 9'd0;
    for (int i = 0; i < int'(BITS_PER_STEP); i++) begin
      trial  = {rem_nx, quo_nx[15]};
      quo_nx = {quo_nx[14:0], 1'b0};
      if (trial >= {1'b0, den}) begin
        trial     = trial - {1'b0, den};
        quo_nx[0] = 1'b1;
      end
      rem_nx = trial[7:0];
    end
  end

  // No reset: an operation in flight always runs to completion.
  always_ff @(posedge clk) begin
    if (in_start && !busy) begin
      busy           <= 1'b1;
      out_data_valid <= 1'b0;
      cnt            <= 3'd0;
      den            <= in_b;
      rem            <= 8'd0;
      quo            <= in_a;
    end else if (busy) begin
      if (cnt == 3'(STEPS)) begin
        busy           <= 1'b0;
        out_data_valid <= 1'b1;
      end else begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + 3'd1;
      end
    end
  end

  assign out_can_accept_cmd = !busy;
  assign out_data           = quo;
endmodule

module snow64_bfloat16_div_fsm (
  input  logic        clk,
  input  logic        in_rst_n,
  input  logic        in_start,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic        out_data_valid,
  output logic        out_can_accept_cmd,
  output logic [15:0] out_data
`ifdef SNOW64_BFLOAT16_DIV_FLAGS_EN
  ,
  output logic [2:0]  out_flags
`endif
);
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SPECIAL,
    ST_DIV_START,
    ST_DIV_WAIT,
    ST_NORMALIZE
  } state_t;

  function automatic logic is_zero(input logic [15:0] x);
    return x[14:7] == 8'h00;
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
  endfunction

  function automatic logic is_nan(input logic [15:0] x);
    return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
  endfunction

  state_t      state;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [8:0]  q_r;
  logic        div_start;
  logic        spec_phase;
  logic        wait_skip;

  logic        div_valid;
  logic        div_can_accept;
  logic [15:0] div_quot;
  logic        unused_quot_hi;

  logic        accept;
  logic        in_special;
  logic        sign;
  logic [15:0] spec_data;
  logic        spec_dbz;
  logic signed [9:0] norm_exp;
  logic [6:0]  norm_mant;
  logic        norm_ovf;
  logic        norm_unf;
  logic [15:0] norm_data;

  snow64_long_div_u16_by_u8 u_div (
    .clk                (clk),
    .in_start           (div_start),
    .in_a               ({1'b1, a_q[6:0], 8'h00}),
    .in_b               ({1'b1, b_q[6:0]}),
    .out_data_valid     (div_valid),
    .out_can_accept_cmd (div_can_accept),
    .out_data           (div_quot)
  );

  assign unused_quot_hi     = ^div_quot[15:9];
  assign out_can_accept_cmd = (state == ST_IDLE) && div_can_accept;
  assign accept             = in_start && out_can_accept_cmd;
  assign in_special         = (in_a[14:7] == 8'h00) || (in_a[14:7] == 8'hFF)
                           || (in_b[14:7] == 8'h00) || (in_b[14:7] == 8'hFF);
  assign sign               = a_q[15] ^ b_q[15];

  // Special-operand result, highest priority first.
  always_comb begin
    spec_data = {sign, 15'h0000};
    spec_dbz  = 1'b0;
    if (is_nan(a_q) || is_nan(b_q) || (is_zero(a_q) && is_zero(b_q))
        || (is_inf(a_q) && is_inf(b_q))) begin
      spec_data = 16'h7FC0;
      spec_dbz  = is_zero(a_q) && is_zero(b_q);
    end else if (is_zero(b_q) || is_inf(a_q)) begin
      spec_data = {sign, 8'hFF, 7'h00};
      spec_dbz  = is_zero(b_q);
    end
  end

  // Quotient lies in [128, 511]; bit 8 selects the exponent bias and mantissa window.
  always_comb begin
    norm_exp  = $signed({2'b00, a_q[14:7]}) - $signed({2'b00, b_q[14:7]})
              + (q_r[8] ? 10'sd127 : 10'sd126);
    norm_mant = q_r[8] ? q_r[7:1] : q_r[6:0];
    norm_ovf  = norm_exp >= 10'sd255;
    norm_unf  = norm_exp <= 10'sd0;
    if (norm_ovf)      norm_data = {sign, 8'hFF, 7'h00};
    else if (norm_unf) norm_data = {sign, 15'h0000};
    else               norm_data = {sign, norm_exp[7:0], norm_mant};
  end

  always_ff @(posedge clk) begin
    if (!in_rst_n) begin
      state          <= ST_IDLE;
      out_data_valid <= 1'b0;
      out_data       <= 16'h0000;
      div_start      <= 1'b0;
      spec_phase     <= 1'b0;
      wait_skip      <= 1'b0;
`ifdef SNOW64_BFLOAT16_DIV_FLAGS_EN
      out_flags      <= 3'b000;
`endif
    end else begin
      div_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            a_q            <= in_a;
            b_q            <= in_b;
            out_data_valid <= 1'b0;
            spec_phase     <= 1'b0;
`ifdef SNOW64_BFLOAT16_DIV_FLAGS_EN
            out_flags      <= 3'b000;
`endif
            if (in_special) begin
              state <= ST_SPECIAL;
            end else begin
              state     <= ST_DIV_START;
              div_start <= 1'b1;
            end
          end
        end
        ST_SPECIAL: begin
          if (!spec_phase) begin
            out_data   <= spec_data;
            spec_phase <= 1'b1;
`ifdef SNOW64_BFLOAT16_DIV_FLAGS_EN
            out_flags  <= {spec_dbz, 2'b00};
`endif
          end else begin
            out_data_valid <= 1'b1;
            spec_phase     <= 1'b0;
            state          <= ST_IDLE;
          end
        end
        ST_DIV_START: begin
          state     <= ST_DIV_WAIT;
          wait_skip <= 1'b1;
        end
        ST_DIV_WAIT: begin
          // First wait cycle ignores the divider's valid from the previous command.
          wait_skip <= 1'b0;
          if (!wait_skip && div_valid) begin
            q_r   <= div_quot[8:0];
            state <= ST_NORMALIZE;
          end
        end
        ST_NORMALIZE: begin
          out_data       <= norm_data;
          out_data_valid <= 1'b1;
          state          <= ST_IDLE;
`ifdef SNOW64_BFLOAT16_DIV_FLAGS_EN
          out_flags      <= {1'b0, norm_ovf, norm_unf};
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifndef SNOW64_BFLOAT16_DIV_FLAGS_EN
  logic unused_spec_dbz;
  assign unused_spec_dbz = spec_dbz;
`endif
endmodule
